wb_stage: RTL and testbench

- Write-back stage directly upstream of the 16x32 register file.
- Latches the MEM-stage result each cycle and selects the write data: ALU result, or memory data for loads.
- Drives the register-file write port with data (PC_OUT), destination (C_OUT) and a one-cycle load strobe (RFLD_OUT).
- Stalls upstream while a load waits on memory, with a timeout counter.
- Exports the current write (plus optionally the previous one) for forwarding to decode.

---
 rtl/wb_stage.sv | 145 ++++++++++++++
 tb/tb_wb_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: selects ALU or load data for the register-file write port and stalls upstream on loads.
// Optional WB_FWD_HISTORY_EN builds a one-deep history of committed writes on FWD1_*.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | accepting MEM-stage instructions, ALU writes issue next edge
// WAIT_MEM | load outstanding, upstream stalled, timeout counter running
module wb_stage #(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 4,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              IN_VALID,
   input  logic              IN_RF_LD,
   input  logic              IN_MEM_RD,
   input  logic [REG_AW-1:0] IN_RD,
   input  logic [DATA_W-1:0] IN_ALU_OUT,
   input  logic [DATA_W-1:0] MEM_DATA,
   input  logic              MEM_READY,
   output logic              STALL,
   output logic [DATA_W-1:0] PC_OUT,
   output logic [REG_AW-1:0] C_OUT,
   output logic              RFLD_OUT,
   output logic              FWD0_VALID,
   output logic [REG_AW-1:0] FWD0_REG,
   output logic [DATA_W-1:0] FWD0_DATA,
   output logic              FWD1_VALID,
   output logic [REG_AW-1:0] FWD1_REG,
   output logic [DATA_W-1:0] FWD1_DATA,
   output logic              ERR
);

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [REG_AW-1:0] c_q, c_d;
   logic              rfld_q, rfld_d;
   logic              err_q, err_d;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= '0;
         pc_q    <= '0;
         c_q     <= '0;
         rfld_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         pc_q    <= pc_d;
         c_q     <= c_d;
         rfld_q  <= rfld_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      pc_d    = pc_q;
      c_d     = c_q;
      rfld_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (IN_VALID && IN_RF_LD) begin
               if (IN_MEM_RD) begin
                  rd_d    = IN_RD;
                  cnt_d   = '0;
                  state_d = WAIT_MEM;
               end else begin
                  pc_d   = IN_ALU_OUT;
                  c_d    = IN_RD;
                  rfld_d = 1'b1;
               end
            end
         end
         WAIT_MEM: begin
            // Data arriving in the last allowed cycle still wins over the timeout.
            if (MEM_READY) begin
               pc_d    = MEM_DATA;
               c_d     = rd_q;
               rfld_d  = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign STALL      = (state_q == WAIT_MEM);
   assign PC_OUT     = pc_q;
   assign C_OUT      = c_q;
   assign RFLD_OUT   = rfld_q;
   assign ERR        = err_q;
   assign FWD0_VALID = rfld_q;
   assign FWD0_REG   = c_q;
   assign FWD0_DATA  = pc_q;

`ifdef WB_FWD_HISTORY_EN
   logic              fwd1_valid_q;
   logic [REG_AW-1:0] fwd1_reg_q;
   logic [DATA_W-1:0] fwd1_data_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         fwd1_valid_q <= 1'b0;
         fwd1_reg_q   <= '0;
         fwd1_data_q  <= '0;
      end else if (rfld_q) begin
         fwd1_valid_q <= 1'b1;
         fwd1_reg_q   <= c_q;
         fwd1_data_q  <= pc_q;
      end
   end

   assign FWD1_VALID = fwd1_valid_q;
   assign FWD1_REG   = fwd1_reg_q;
   assign FWD1_DATA  = fwd1_data_q;
`else
   assign FWD1_VALID = 1'b0;
   assign FWD1_REG   = '0;
   assign FWD1_DATA  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: transaction-level model compared every cycle plus hand-computed literal checks.
module tb_wb_stage;

   localparam int TO = 16;
`ifdef WB_FWD_HISTORY_EN
   localparam bit HIST = 1'b1;
`else
   localparam bit HIST = 1'b0;
`endif

   logic        CLK, RST_N, IN_VALID, IN_RF_LD, IN_MEM_RD, MEM_READY;
   logic [3:0]  IN_RD;
   logic [31:0] IN_ALU_OUT, MEM_DATA;
   logic        STALL, RFLD_OUT, FWD0_VALID, FWD1_VALID, ERR;
   logic [31:0] PC_OUT, FWD0_DATA, FWD1_DATA;
   logic [3:0]  C_OUT, FWD0_REG, FWD1_REG;

   wb_stage #(.DATA_W(32), .REG_AW(4), .MEM_TIMEOUT(TO)) dut (
      .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_RF_LD(IN_RF_LD),
      .IN_MEM_RD(IN_MEM_RD), .IN_RD(IN_RD), .IN_ALU_OUT(IN_ALU_OUT),
      .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY), .STALL(STALL),
      .PC_OUT(PC_OUT), .C_OUT(C_OUT), .RFLD_OUT(RFLD_OUT),
      .FWD0_VALID(FWD0_VALID), .FWD0_REG(FWD0_REG), .FWD0_DATA(FWD0_DATA),
      .FWD1_VALID(FWD1_VALID), .FWD1_REG(FWD1_REG), .FWD1_DATA(FWD1_DATA),
      .ERR(ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a load is an outstanding request that has waited m_wait cycles; it
   // commits when memory answers or is abandoned after TO cycles of waiting.
   bit         m_busy, m_rfld, m_err, m_f1v;
   int         m_wait;
   logic [3:0] m_dest, m_c, m_f1c;
   logic [31:0] m_pc, m_f1d;

   task automatic model_step();
      bit          pv;
      logic [3:0]  pc_reg;
      logic [31:0] pd;
      if (!RST_N) begin
         m_busy = 0; m_rfld = 0; m_err = 0; m_f1v = 0; m_wait = 0;
         m_dest = '0; m_c = '0; m_f1c = '0; m_pc = '0; m_f1d = '0;
      end else begin
         pv = m_rfld; pc_reg = m_c; pd = m_pc;
         m_rfld = 0;
         if (m_busy) begin
            m_wait++;
            if (MEM_READY) begin
               m_busy = 0; m_rfld = 1; m_c = m_dest; m_pc = MEM_DATA;
            end else if (m_wait == TO) begin
               m_busy = 0; m_err = 1;
            end
         end else if (IN_VALID && IN_RF_LD) begin
            if (IN_MEM_RD) begin
               m_busy = 1; m_wait = 0; m_dest = IN_RD;
            end else begin
               m_rfld = 1; m_c = IN_RD; m_pc = IN_ALU_OUT;
            end
         end
         if (HIST && pv) begin
            m_f1v = 1; m_f1c = pc_reg; m_f1d = pd;
         end
      end
   endtask

   initial begin
      m_busy = 0; m_rfld = 0; m_err = 0; m_f1v = 0; m_wait = 0;
      m_dest = '0; m_c = '0; m_f1c = '0; m_pc = '0; m_f1d = '0;
      forever begin
         @(posedge CLK);
         model_step();
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("stall", STALL, m_busy);
         chk("rfld", RFLD_OUT, m_rfld);
         chk("c_out", C_OUT, m_c);
         chk("pc_out", PC_OUT, m_pc);
         chk("err", ERR, m_err);
         chk("fwd0_valid", FWD0_VALID, m_rfld);
         chk("fwd0_reg", FWD0_REG, m_c);
         chk("fwd0_data", FWD0_DATA, m_pc);
         chk("fwd1_valid", FWD1_VALID, m_f1v);
         chk("fwd1_reg", FWD1_REG, m_f1c);
         chk("fwd1_data", FWD1_DATA, m_f1d);
      end
   end

   task automatic drv(input bit v, input bit ld, input bit mrd, input logic [3:0] rd,
                      input logic [31:0] alu, input bit mr, input logic [31:0] md);
      IN_VALID = v; IN_RF_LD = ld; IN_MEM_RD = mrd; IN_RD = rd;
      IN_ALU_OUT = alu; MEM_READY = mr; MEM_DATA = md;
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   int n;

   initial begin
      RST_N = 1'b0;
      drv(0, 0, 0, 4'd0, 32'd0, 0, 32'd0);
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_stall", STALL, 0);
      chk("rst_rfld", RFLD_OUT, 0);
      chk("rst_pc", PC_OUT, 0);
      chk("rst_err", ERR, 0);

      // ALU write R5 = 73
      RST_N = 1'b1;
      drv(1, 1, 0, 4'b0101, 32'd73, 0, 32'd0);
      tick();
      chk("alu_rfld", RFLD_OUT, 1);
      chk("alu_c", C_OUT, 5);
      chk("alu_pc", PC_OUT, 73);
      chk("alu_fwd0", {FWD0_VALID, FWD0_REG, FWD0_DATA[7:0]}, {1'b1, 4'd5, 8'd73});
      drv(0, 0, 0, 4'd0, 32'd0, 0, 32'd0);
      tick();
      chk("alu_rfld_drop", RFLD_OUT, 0);

      // load R10, data ready in the third wait cycle; IN_* toggling must be ignored
      drv(1, 1, 1, 4'b1010, 32'd999, 0, 32'd0);
      tick();
      chk("ld_stall1", STALL, 1);
      drv(1, 1, 0, 4'd2, 32'd55, 0, 32'd0);
      tick();
      chk("ld_stall2", STALL, 1);
      tick();
      chk("ld_stall3", STALL, 1);
      drv(0, 0, 0, 4'd0, 32'd0, 1, 32'd16);
      tick();
      chk("ld_rfld", RFLD_OUT, 1);
      chk("ld_c", C_OUT, 10);
      chk("ld_pc", PC_OUT, 16);
      chk("ld_stall_end", STALL, 0);
      drv(0, 0, 0, 4'd0, 32'd0, 0, 32'd0);
      tick();

      // MEM_READY on the final allowed wait cycle
      drv(1, 1, 1, 4'd6, 32'd1, 0, 32'd0);
      tick();
      drv(0, 0, 0, 4'd0, 32'd0, 0, 32'd0);
      for (int i = 0; i < TO - 1; i++) tick();
      chk("edge_stall", STALL, 1);
      drv(0, 0, 0, 4'd0, 32'd0, 1, 32'hCAFE);
      tick();
      chk("edge_rfld", RFLD_OUT, 1);
      chk("edge_pc", PC_OUT, 32'hCAFE);
      chk("edge_c", C_OUT, 6);
      chk("edge_err", ERR, 0);
      drv(0, 0, 0, 4'd0, 32'd0, 0, 32'd0);
      tick();

      // timeout: 16 cycles of stall, no write, sticky ERR
      drv(1, 1, 1, 4'd9, 32'd1, 0, 32'd0);
      tick();
      drv(0, 0, 0, 4'd0, 32'd0, 0, 32'd0);
      n = 1;
      while (STALL && n < 40) begin
         tick();
         if (STALL) n++;
      end
      chk("to_stall_cycles", n, TO);
      chk("to_err", ERR, 1);
      chk("to_rfld", RFLD_OUT, 0);
      chk("to_c_hold", C_OUT, 6);
      drv(1, 1, 0, 4'd1, 32'd7, 0, 32'd0);
      tick();
      chk("to_err_sticky", ERR, 1);
      chk("to_later_write", RFLD_OUT, 1);

      // back-to-back writes R3=90 then R7=50
      drv(1, 1, 0, 4'd3, 32'd90, 0, 32'd0);
      tick();
      drv(1, 1, 0, 4'd7, 32'd50, 0, 32'd0);
      tick();
      chk("hist_fwd0", {FWD0_VALID, FWD0_REG, FWD0_DATA[7:0]}, {1'b1, 4'd7, 8'd50});
      chk("hist_fwd1", {FWD1_VALID, FWD1_REG, FWD1_DATA[7:0]},
          HIST ? {1'b1, 4'd3, 8'd90} : 13'd0);
      // R15 written like any other register
      drv(1, 1, 0, 4'd15, 32'hFFFF_0001, 0, 32'd0);
      tick();
      chk("r15_c", C_OUT, 15);
      drv(0, 0, 0, 4'd0, 32'd0, 0, 32'd0);
      tick();

      // reset while waiting on memory, with MEM_READY high in the same cycle
      drv(1, 1, 1, 4'd12, 32'd3, 0, 32'd0);
      tick();
      drv(0, 0, 0, 4'd0, 32'd0, 0, 32'd0);
      tick();
      RST_N = 1'b0;
      drv(0, 0, 0, 4'd0, 32'd0, 1, 32'd77);
      tick();
      chk("mrst_stall", STALL, 0);
      chk("mrst_rfld", RFLD_OUT, 0);
      chk("mrst_pc", PC_OUT, 0);
      chk("mrst_c", C_OUT, 0);
      chk("mrst_err", ERR, 0);
      chk("mrst_fwd1", {FWD1_VALID, FWD1_REG, FWD1_DATA}, 37'd0);
      RST_N = 1'b1;
      drv(0, 0, 0, 4'd0, 32'd0, 0, 32'd0);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
